// File: rtl/lpddr3_dm_lane_tx_ctrl.sv
// lpddr3_dm_lane_tx_ctrl
// Fabric-side write-path controller for one LPDDR3 DM lane. It turns BL8
// write-mask requests into TX/OE words at write latency, drives ODT during
// reads, and sequences delay-line load/move pulses for training.
// Optional build macro: LPDDR3_DM_OE_POSTAMBLE_EN adds one OE postamble
// cycle after the last burst of a train.
//
// Handshake: a write burst is taken on any rising FAB_CLK edge where
// wr_valid & wr_ready are both 1. wr_ready is registered, so it never
// depends combinationally on wr_valid. The requester holds wr_valid and
// wr_mask stable until that edge.
module lpddr3_dm_lane_tx_ctrl #(
    parameter int WL_CYCLES  = 4,
    parameter int PRE_CYCLES = 1,
    parameter int MOVE_GAP   = 3
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_mask,
    input  logic       rd_active,
    input  logic       dly_req,
    input  logic       dly_load,
    input  logic       dly_dir,
    input  logic [7:0] dly_steps,
    output logic       dly_busy,
    output logic       dly_done,
    output logic       dly_oor,
    output logic [7:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    output logic       ODT_EN_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic [2:0] dly_state
);

    // The preamble looks ahead into the pipeline; it cannot look further
    // than the accept cycle itself.
    localparam int PRE_EFF = (PRE_CYCLES < WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
    localparam logic [7:0] GAP_LOAD = 8'(MOVE_GAP - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MOVE = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } dly_state_t;

    dly_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;
    logic       dir_q, dir_d;
    logic       oor_d;
    logic       oor_hit;
    logic       act;

    logic                 accept;
    logic [WL_CYCLES-1:0] pv_q;
    logic [7:0]           pm_q  [0:WL_CYCLES-1];
    logic [WL_CYCLES:0]   v_all;
    logic [7:0]           m_all [0:WL_CYCLES];
    logic                 look;
    logic                 burst_q;
    logic [7:0]           tx_d;
    logic [3:0]           oe_d;

    assign accept    = wr_valid & wr_ready;
    assign dly_state = state_q;

    // Stage view of the write pipeline: index 0 is the accept cycle,
    // index WL_CYCLES is the slot being presented on TX this cycle.
    always_comb begin
        v_all    = {pv_q, accept};
        m_all[0] = wr_mask;
        for (int i = 1; i <= WL_CYCLES; i++) m_all[i] = pm_q[i-1];
    end

    // Write pipeline shift register with per-slot valid bits.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            pv_q <= '0;
            for (int i = 0; i < WL_CYCLES; i++) pm_q[i] <= 8'h00;
        end else begin
            for (int i = 0; i < WL_CYCLES; i++) begin
                pv_q[i] <= v_all[i];
                pm_q[i] <= m_all[i];
            end
        end
    end

    // Next TX/OE words: data at the output slot, OE covering the slot plus
    // any burst within the preamble window (and optionally a postamble).
    always_comb begin
        look = 1'b0;
        for (int d = 0; d <= PRE_EFF; d++) look = look | v_all[WL_CYCLES-d];
        tx_d = v_all[WL_CYCLES] ? m_all[WL_CYCLES] : 8'h00;
`ifdef LPDDR3_DM_OE_POSTAMBLE_EN
        oe_d = (look | burst_q) ? 4'hF : 4'h0;
`else
        oe_d = look ? 4'hF : 4'h0;
`endif
    end

    // Registered TX/OE/ODT outputs; ODT uses next-cycle OE so the two never overlap.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            TX_DATA_0 <= 8'h00;
            OE_DATA_0 <= 4'h0;
            ODT_EN_0  <= 1'b0;
            burst_q   <= 1'b0;
        end else begin
            TX_DATA_0 <= tx_d;
            OE_DATA_0 <= oe_d;
            ODT_EN_0  <= rd_active & ~(|oe_d);
            burst_q   <= v_all[WL_CYCLES];
        end
    end

    // Delay FSM state register and captured request fields.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= IDLE;
            cnt_q   <= 8'h00;
            gap_q   <= 8'h00;
            dir_q   <= 1'b0;
            dly_oor <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dir_q   <= dir_d;
            dly_oor <= oor_d;
        end
    end

    // Delay FSM next-state logic, sticky out-of-range tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        dir_d   = dir_q;
        oor_d   = dly_oor;
        oor_hit = dly_oor | DELAY_LINE_OUT_OF_RANGE_0;
        if (state_q == IDLE) begin
            if (dly_req) oor_d = 1'b0;
        end else if (DELAY_LINE_OUT_OF_RANGE_0) begin
            oor_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (dly_req) begin
                    dir_d = dly_dir;
                    cnt_d = dly_steps;
                    if (dly_load)             state_d = LOAD;
                    else if (dly_steps != 0)  state_d = MOVE;
                    else                      state_d = DONE;
                end
            end
            LOAD: state_d = (cnt_q != 0 && !oor_hit) ? MOVE : DONE;
            MOVE: begin
                cnt_d   = cnt_q - 8'd1;
                gap_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q != 0)                  gap_d   = gap_q - 8'd1;
                else if (cnt_q == 0 || oor_hit) state_d = DONE;
                else                             state_d = MOVE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign act = (state_d != IDLE) | (state_q != IDLE);

    // Registered delay-line pulses, status and write back-pressure.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            DELAY_LINE_LOAD_0      <= 1'b0;
            DELAY_LINE_MOVE_0      <= 1'b0;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
            dly_done               <= 1'b0;
            dly_busy               <= 1'b0;
            wr_ready               <= 1'b0;
        end else begin
            DELAY_LINE_LOAD_0      <= (state_q == LOAD);
            DELAY_LINE_MOVE_0      <= (state_q == MOVE);
            DELAY_LINE_DIRECTION_0 <= act & dir_d;
            dly_done               <= (state_q == DONE);
            dly_busy               <= act;
            wr_ready               <= ~act & ~rd_active;
        end
    end

endmodule

// File: tb/tb_lpddr3_dm_lane_tx_ctrl.sv
// Directed bench for lpddr3_dm_lane_tx_ctrl (WL=4, PRE=1, MOVE_GAP=3).
module tb_lpddr3_dm_lane_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_mask;
    logic       rd_active;
    logic       dly_req;
    logic       dly_load;
    logic       dly_dir;
    logic [7:0] dly_steps;
    logic       dly_busy;
    logic       dly_done;
    logic       dly_oor;
    logic [7:0] tx_data;
    logic [3:0] oe_data;
    logic       odt_en;
    logic       dl_load;
    logic       dl_move;
    logic       dl_dir;
    logic       dl_oor;
    logic [2:0] dly_state;

    int n_checks = 0;
    int n_errors = 0;

    lpddr3_dm_lane_tx_ctrl #(
        .WL_CYCLES (4),
        .PRE_CYCLES(1),
        .MOVE_GAP  (3)
    ) dut (
        .FAB_CLK                  (clk),
        .ARST_N                   (rst_n),
        .wr_valid                 (wr_valid),
        .wr_ready                 (wr_ready),
        .wr_mask                  (wr_mask),
        .rd_active                (rd_active),
        .dly_req                  (dly_req),
        .dly_load                 (dly_load),
        .dly_dir                  (dly_dir),
        .dly_steps                (dly_steps),
        .dly_busy                 (dly_busy),
        .dly_done                 (dly_done),
        .dly_oor                  (dly_oor),
        .TX_DATA_0                (tx_data),
        .OE_DATA_0                (oe_data),
        .ODT_EN_0                 (odt_en),
        .DELAY_LINE_LOAD_0        (dl_load),
        .DELAY_LINE_MOVE_0        (dl_move),
        .DELAY_LINE_DIRECTION_0   (dl_dir),
        .DELAY_LINE_OUT_OF_RANGE_0(dl_oor),
        .dly_state                (dly_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] tbl [0:2];
        logic [3:0] oe_exp;
        logic [7:0] tx_exp;
        tbl[0] = 8'h01; tbl[1] = 8'h80; tbl[2] = 8'hFF;

        rst_n = 1'b0; wr_valid = 1'b0; wr_mask = 8'h00; rd_active = 1'b0;
        dly_req = 1'b0; dly_load = 1'b0; dly_dir = 1'b0; dly_steps = 8'h00;
        dl_oor = 1'b0;

        // Reset state
        step(); step();
        check("rst_tx", 32'(tx_data), 32'h00);
        check("rst_oe", 32'(oe_data), 32'h0);
        check("rst_ready", 32'(wr_ready), 32'h0);
        check("rst_busy", 32'(dly_busy), 32'h0);
        check("rst_odt", 32'(odt_en), 32'h0);
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 32'(wr_ready), 32'h1);

        // Single write 8'hA5: preamble at +3, data at +4, idle at +5
        for (int n = 0; n <= 6; n++) begin
            wr_valid = (n == 0);
            wr_mask  = 8'hA5;
            step();
            tx_exp = (n == 4) ? 8'hA5 : 8'h00;
            oe_exp = (n == 3 || n == 4) ? 4'hF : 4'h0;
`ifdef LPDDR3_DM_OE_POSTAMBLE_EN
            if (n == 5) oe_exp = 4'hF;
`endif
            check($sformatf("w1_tx_%0d", n), 32'(tx_data), 32'(tx_exp));
            check($sformatf("w1_oe_%0d", n), 32'(oe_data), 32'(oe_exp));
        end

        // Three back-to-back writes
        for (int n = 0; n <= 8; n++) begin
            wr_valid = (n < 3);
            wr_mask  = (n < 3) ? tbl[n] : 8'h00;
            step();
            tx_exp = (n >= 4 && n <= 6) ? tbl[n-4] : 8'h00;
            oe_exp = (n >= 3 && n <= 6) ? 4'hF : 4'h0;
`ifdef LPDDR3_DM_OE_POSTAMBLE_EN
            if (n == 7) oe_exp = 4'hF;
`endif
            check($sformatf("w3_tx_%0d", n), 32'(tx_data), 32'(tx_exp));
            check($sformatf("w3_oe_%0d", n), 32'(oe_data), 32'(oe_exp));
            check($sformatf("w3_odt_%0d", n), 32'(odt_en), 32'h0);
        end

        // Delay sequence: load, 3 moves 4 cycles apart, done
        for (int n = 0; n <= 16; n++) begin
            dly_req   = (n == 0);
            dly_load  = 1'b1;
            dly_dir   = 1'b1;
            dly_steps = 8'd3;
            step();
            check($sformatf("d_load_%0d", n), 32'(dl_load), 32'(n == 1));
            check($sformatf("d_move_%0d", n), 32'(dl_move), 32'(n == 2 || n == 6 || n == 10));
            check($sformatf("d_done_%0d", n), 32'(dly_done), 32'(n == 14));
            check($sformatf("d_busy_%0d", n), 32'(dly_busy), 32'(n <= 14));
            check($sformatf("d_dir_%0d", n), 32'(dl_dir), 32'(n <= 14));
            check($sformatf("d_ready_%0d", n), 32'(wr_ready), 32'(n >= 15));
        end
        dly_dir = 1'b0;

        // Out-of-range after the first move stops further moves
        for (int n = 0; n <= 9; n++) begin
            dly_req   = (n == 0);
            dly_load  = 1'b1;
            dly_dir   = 1'b1;
            dly_steps = 8'd3;
            dl_oor    = (n >= 3);
            step();
            check($sformatf("o_move_%0d", n), 32'(dl_move), 32'(n == 2));
            check($sformatf("o_done_%0d", n), 32'(dly_done), 32'(n == 6));
            check($sformatf("o_oor_%0d", n), 32'(dly_oor), 32'(n >= 3));
        end
        dl_oor = 1'b0;
        step();
        check("oor_sticky", 32'(dly_oor), 32'h1);
        dly_req = 1'b1; dly_load = 1'b0; dly_steps = 8'd0; dly_dir = 1'b0;
        step();
        dly_req = 1'b0;
        check("oor_cleared", 32'(dly_oor), 32'h0);
        check("noop_state", 32'(dly_state), 32'd4);
        step();
        check("noop_done", 32'(dly_done), 32'h1);
        check("noop_move", 32'(dl_move), 32'h0);
        step(); step();

        // Read burst: ODT follows rd_active one cycle later, writes held off
        for (int n = 0; n <= 6; n++) begin
            rd_active = (n < 5);
            step();
            check($sformatf("r_odt_%0d", n), 32'(odt_en), 32'(n < 5));
            check($sformatf("r_ready_%0d", n), 32'(wr_ready), 32'(n >= 5));
        end

        // Two writes, second together with a delay request, then reset mid-GAP
        wr_valid = 1'b1; wr_mask = 8'h3C;
        step();
        wr_mask = 8'hC3; dly_req = 1'b1; dly_load = 1'b0; dly_dir = 1'b1; dly_steps = 8'd3;
        step();
        wr_valid = 1'b0; dly_req = 1'b0;
        check("prio_ready", 32'(wr_ready), 32'h0);
        check("prio_busy", 32'(dly_busy), 32'h1);
        step();
        check("prio_move", 32'(dl_move), 32'h1);
        step();
        check("gap_state", 32'(dly_state), 32'd3);
        check("gap_preamble", 32'(oe_data), 32'hF);
        check("gap_dir", 32'(dl_dir), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx", 32'(tx_data), 32'h00);
        check("arst_oe", 32'(oe_data), 32'h0);
        check("arst_dir", 32'(dl_dir), 32'h0);
        check("arst_busy", 32'(dly_busy), 32'h0);
        check("arst_state", 32'(dly_state), 32'd0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            step();
            check($sformatf("post_tx_%0d", n), 32'(tx_data), 32'h00);
            check($sformatf("post_oe_%0d", n), 32'(oe_data), 32'h0);
            check($sformatf("post_move_%0d", n), 32'(dl_move), 32'h0);
            check($sformatf("post_state_%0d", n), 32'(dly_state), 32'd0);
            check($sformatf("post_ready_%0d", n), 32'(wr_ready), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lpddr3_dm_lane_tx_ctrl.md
Name: lpddr3_dm_lane_tx_ctrl

Overview:
Fabric-side write-path controller for one LPDDR3 DM lane. It sits directly upstream of the lane's DM I/O delay wrapper.
- Converts per-burst BL8 write-mask requests into the 8-bit serial TX data word and 4-bit output-enable word at write latency.
- Generates ODT enable during reads.
- Sequences delay-line load/move pulses for write-levelling/deskew training.
- Consumes the delay line's out-of-range flag.

Parameters:
WL_CYCLES, 4, write latency in FAB_CLK cycles from request accept to DM burst on TX_DATA (legal 1..15).
PRE_CYCLES, 1, OE preamble cycles before the first burst of a write train (0..2).
MOVE_GAP, 3, FAB_CLK cycles between consecutive delay-line move pulses (>=1).

Ports:
FAB_CLK  in  1  fabric clock, 8 UI per cycle; sole clock.
ARST_N  in  1  asynchronous active-low reset.
wr_valid  in  1  write burst request.
wr_ready  out  1  request accepted when wr_valid & wr_ready.
wr_mask  in  8  DM bits for beats 0..7; bit0 is the first UI.
rd_active  in  1  read burst in flight on this lane.
dly_req  in  1  start delay adjustment; sampled only in IDLE.
dly_load  in  1  with dly_req: reset delay line to its load value before moving.
dly_dir  in  1  move direction (1 = increment).
dly_steps  in  8  number of move pulses (0 = load only / no-op).
dly_busy  out  1  delay FSM not in IDLE.
dly_done  out  1  one-cycle pulse on FSM completion.
dly_oor  out  1  sticky out-of-range flag; cleared by next accepted dly_req.
TX_DATA_0  out  8  serial DM word to the IOD.
OE_DATA_0  out  4  output enable, one bit per 2 UI.
ODT_EN_0  out  1  ODT enable to the IOD.
DELAY_LINE_LOAD_0  out  1  delay-line load pulse.
DELAY_LINE_MOVE_0  out  1  delay-line move pulse.
DELAY_LINE_DIRECTION_0  out  1  move direction.
DELAY_LINE_OUT_OF_RANGE_0  in  1  delay line saturated.

Behaviour:
Reset:
- All outputs are registered.
- While ARST_N = 0: TX_DATA_0 = 8'h00, OE_DATA_0 = 4'h0, ODT_EN_0 = 0, all DELAY_LINE_* = 0, wr_ready = 0, dly_busy = 0, dly_done = 0, dly_oor = 0.
- wr_ready rises on the first FAB_CLK edge after deassertion.
- A reset asserted mid-burst or mid-move flushes the pipeline and returns the FSM to IDLE immediately.

Write path:
- Accept: wr_mask enters a WL_CYCLES-deep pipeline with a valid bit.
- At the output stage: TX_DATA_0 = wr_mask and OE_DATA_0 = 4'hF exactly WL_CYCLES cycles after the accept edge.
- Preamble: OE_DATA_0 = 4'hF for PRE_CYCLES cycles before a burst whose predecessor slot was empty; TX_DATA_0 = 0 during preamble.
- Back-to-back accepts produce continuous OE with no gap and no inserted preamble.
- Idle: TX_DATA_0 = 0, OE_DATA_0 = 0.
- wr_ready = 0 while dly_busy = 1, and while rd_active = 1.

ODT:
- ODT_EN_0 = registered (rd_active & ~any OE bit), with one cycle latency.
- Never asserted in the same cycle as non-zero OE_DATA_0.

Delay FSM states: IDLE, LOAD, MOVE, GAP, DONE.
- IDLE: on dly_req, capture dly_dir, dly_steps and dly_load; clear dly_oor. Go to LOAD if dly_load = 1, else MOVE if steps > 0, else DONE.
- LOAD: DELAY_LINE_LOAD_0 = 1 for one cycle; then MOVE if steps > 0, else DONE.
- MOVE: DELAY_LINE_MOVE_0 = 1 for one cycle; decrement the remaining count; go to GAP.
- GAP: wait MOVE_GAP cycles. Then DONE if the count is 0 or DELAY_LINE_OUT_OF_RANGE_0 = 1; otherwise MOVE.
- DONE: dly_done = 1 for one cycle; return to IDLE.
- DELAY_LINE_DIRECTION_0 is held at the captured dir from LOAD through DONE, is stable one cycle before each move pulse, and returns to 0 in IDLE.
- Out-of-range sampled = 1 in any non-IDLE state sets dly_oor; no further move pulses are issued.
- dly_req while busy is ignored.
- dly_req and wr_valid in the same IDLE cycle: the delay request wins and wr_ready drops the next cycle. A write accepted in the same cycle still completes.

Optional Feature:
LPDDR3_DM_OE_POSTAMBLE_EN:
- Defined: OE_DATA_0 = 4'hF for one extra cycle after the last burst of a train, with TX_DATA_0 = 0; ODT_EN_0 is held off during that cycle.
- Undefined: OE drops on the cycle after the last burst.

Test Plan:
- Reset release, then a single wr_valid with wr_mask = 8'hA5 (WL = 4, PRE = 1) -> OE_DATA_0 = F at accept + 3 with TX = 00; TX = A5/OE = F at accept + 4; both 0 at accept + 5.
- Three back-to-back writes 8'h01, 8'h80, 8'hFF -> TX sequence 01, 80, FF on consecutive cycles; OE continuous for 4 cycles (1 preamble + 3).
- dly_req, load = 1, dir = 1, steps = 3, MOVE_GAP = 3 -> LOAD pulse; 3 MOVE pulses 4 cycles apart; DIRECTION = 1 throughout; dly_done 1 cycle; wr_ready low until IDLE.
- Same as above with OUT_OF_RANGE forced high after the first move -> exactly 1 move pulse, dly_oor = 1, dly_done fires; next dly_req clears dly_oor.
- rd_active = 1 for 5 cycles with no writes -> ODT_EN_0 high for 5 cycles, 1-cycle delayed; wr_ready low during those cycles.
- ARST_N asserted mid-GAP with 2 writes in the pipeline -> all outputs 0 immediately; after release no stale TX/OE appears and the FSM is in IDLE.
